cpu_bus: RTL and testbench



---
 rtl/cpu_bus_pkg.sv | 38 +++
 rtl/cpu_bus_work_ram.sv | 25 ++
 rtl/cpu_bus.sv | 176 +++++++++++++++++
 tb/tb_cpu_bus.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-side memory bus.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_PPU,
    REGION_IO,
    REGION_CART
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    RAM_WAIT,
    EXT_WAIT,
    DONE
  } state_t;

  // First address of each region above work RAM.
  localparam logic [15:0] PPU_BASE  = 16'h2000;
  localparam logic [15:0] IO_BASE   = 16'h4000;
  localparam logic [15:0] CART_BASE = 16'h4020;

  localparam logic [7:0] OPEN_BUS_RESET = 8'h00;

  // Map a CPU address onto the target that owns it.
  function automatic region_t decode_region(input logic [15:0] address);
    if (address < PPU_BASE) begin
      return REGION_RAM;
    end else if (address < IO_BASE) begin
      return REGION_PPU;
    end else if (address < CART_BASE) begin
      return REGION_IO;
    end else begin
      return REGION_CART;
    end
  endfunction

endpackage

// File: rtl/cpu_bus_work_ram.sv
// Single-port work RAM: synchronous write, registered read, contents not reset.
module work_ram #(
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clock_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            rdata_o
);

  logic [7:0] mem [2**ADDR_WIDTH];

  // One access per enabled cycle; read returns the pre-write contents.
  always_ff @(posedge clock_i) begin
    if (enable_i) begin
      if (write_i) begin
        mem[address_i] <= wdata_i;
      end
      rdata_o <= mem[address_i];
    end
  end

endmodule

// File: rtl/cpu_bus.sv
// CPU-side bus: decodes each CPU request to work RAM or one of three external
// targets (PPU, APU/IO, cartridge), and completes it with NES-style open bus.
module cpu_bus
  import cpu_bus_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 11,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] cpu_address_i,
  input  logic        cpu_address_valid_i,
  input  logic        cpu_write_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  output logic        cpu_data_valid_o,
  output logic [15:0] ext_address_o,
  output logic        ext_write_o,
  output logic [7:0]  ext_wdata_o,
  output logic        ppu_req_o,
  output logic        io_req_o,
  output logic        cart_req_o,
  input  logic        ppu_ack_i,
  input  logic        io_ack_i,
  input  logic        cart_ack_i,
  input  logic [7:0]  ppu_rdata_i,
  input  logic [7:0]  io_rdata_i,
  input  logic [7:0]  cart_rdata_i,
  output logic        timeout_o
);

  localparam int unsigned COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                 state_q;
  state_t                 state_d;
  region_t                region_q;
  region_t                new_region;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [7:0]             open_bus_q;
  logic [7:0]             ram_rdata;
  logic                   ram_access;
  logic                   sel_ack;
  logic [7:0]             sel_rdata;
  logic                   timed_out;
  logic                   same_request;

  // Decode the incoming request and route the selected target's ack/data.
  always_comb begin
    new_region   = decode_region(cpu_address_i);
    ram_access   = (state_q == IDLE) && cpu_address_valid_i && (new_region == REGION_RAM);
    timed_out    = (count_q == COUNT_LAST);
    same_request = cpu_address_valid_i
                && (cpu_address_i == ext_address_o)
                && (cpu_write_i == ext_write_o);
    sel_ack      = 1'b0;
    sel_rdata    = '0;
    case (region_q)
      REGION_PPU: begin
        sel_ack   = ppu_ack_i;
        sel_rdata = ppu_rdata_i;
      end
      REGION_IO: begin
        sel_ack   = io_ack_i;
        sel_rdata = io_rdata_i;
      end
      REGION_CART: begin
        sel_ack   = cart_ack_i;
        sel_rdata = cart_rdata_i;
      end
      default: ;
    endcase
  end

  // Next-state and CPU-facing outputs.
  always_comb begin
    state_d          = state_q;
    cpu_data_valid_o = (state_q == DONE);
    // The open-bus latch always holds the most recent completion, so it
    // doubles as the read-data register seen by the CPU.
    cpu_rdata_o      = open_bus_q;
    case (state_q)
      IDLE: begin
        if (cpu_address_valid_i) begin
          state_d = (new_region == REGION_RAM) ? RAM_WAIT : EXT_WAIT;
        end
      end
      RAM_WAIT: state_d = DONE;
      EXT_WAIT: begin
        if (sel_ack || timed_out) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // A held, unchanged request is not re-issued; any change costs one
        // idle bubble before the next request is accepted.
        if (!same_request) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, external handshake, timeout counter and open-bus capture.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      region_q      <= REGION_RAM;
      ext_address_o <= '0;
      ext_write_o   <= 1'b0;
      ext_wdata_o   <= '0;
      ppu_req_o     <= 1'b0;
      io_req_o      <= 1'b0;
      cart_req_o    <= 1'b0;
      count_q       <= '0;
      timeout_o     <= 1'b0;
      open_bus_q    <= OPEN_BUS_RESET;
    end else begin
      timeout_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_address_valid_i) begin
            region_q      <= new_region;
            ext_address_o <= cpu_address_i;
            ext_write_o   <= cpu_write_i;
            ext_wdata_o   <= cpu_wdata_i;
            count_q       <= '0;
            ppu_req_o     <= (new_region == REGION_PPU);
            io_req_o      <= (new_region == REGION_IO);
            cart_req_o    <= (new_region == REGION_CART);
          end
        end
        RAM_WAIT: begin
          open_bus_q <= ext_write_o ? ext_wdata_o : ram_rdata;
        end
        EXT_WAIT: begin
          if (sel_ack || timed_out) begin
            ppu_req_o  <= 1'b0;
            io_req_o   <= 1'b0;
            cart_req_o <= 1'b0;
            timeout_o  <= !sel_ack;
            if (ext_write_o) begin
              open_bus_q <= ext_wdata_o;
            end else if (sel_ack) begin
              open_bus_q <= sel_rdata;
            end
          end else begin
            count_q <= count_q + COUNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  work_ram #(
    .ADDR_WIDTH(RAM_ADDR_WIDTH)
  ) u_work_ram (
    .clock_i   (clock_i),
    .enable_i  (ram_access),
    .write_i   (cpu_write_i),
    .address_i (cpu_address_i[RAM_ADDR_WIDTH-1:0]),
    .wdata_i   (cpu_wdata_i),
    .rdata_o   (ram_rdata)
  );

endmodule

// File: tb/tb_cpu_bus.sv
// Self-checking bench for cpu_bus: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_cpu_bus;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [15:0] cpu_address;
  logic        cpu_valid;
  logic        cpu_write;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata_o;
  logic        cpu_data_valid_o;
  logic [15:0] ext_address_o;
  logic        ext_write_o;
  logic [7:0]  ext_wdata_o;
  logic        ppu_req_o, io_req_o, cart_req_o;
  logic        ppu_ack_i, io_ack_i, cart_ack_i;
  logic [7:0]  ppu_rdata_i, io_rdata_i, cart_rdata_i;
  logic        timeout_o;

  // Target responders: index 0 = PPU, 1 = IO, 2 = CART.
  logic [2:0]  ack_v;
  logic [2:0]  req_vec;
  logic [7:0]  garb;
  int          lat [3];        // ack in the lat-th request cycle, 0 = never
  logic [7:0]  tdata [3];
  bit          noise [3];      // hold ack high regardless of request
  int          rcnt [3];
  int          req_cycles [3];
  int          timeout_pulses;

  int          passed = 0;
  int          total  = 0;

  // Reference model state.
  logic [7:0]  ram_model [2048];
  bit          ram_valid [2048];
  logic [7:0]  ob;

  always #5 clock_i = ~clock_i;

  assign req_vec      = {cart_req_o, io_req_o, ppu_req_o};
  assign ppu_ack_i    = ack_v[0];
  assign io_ack_i     = ack_v[1];
  assign cart_ack_i   = ack_v[2];
  assign ppu_rdata_i  = ack_v[0] ? tdata[0] : garb;
  assign io_rdata_i   = ack_v[1] ? tdata[1] : garb;
  assign cart_rdata_i = ack_v[2] ? tdata[2] : garb;

  cpu_bus #(
    .RAM_ADDR_WIDTH(11),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .cpu_address_i       (cpu_address),
    .cpu_address_valid_i (cpu_valid),
    .cpu_write_i         (cpu_write),
    .cpu_wdata_i         (cpu_wdata),
    .cpu_rdata_o         (cpu_rdata_o),
    .cpu_data_valid_o    (cpu_data_valid_o),
    .ext_address_o       (ext_address_o),
    .ext_write_o         (ext_write_o),
    .ext_wdata_o         (ext_wdata_o),
    .ppu_req_o           (ppu_req_o),
    .io_req_o            (io_req_o),
    .cart_req_o          (cart_req_o),
    .ppu_ack_i           (ppu_ack_i),
    .io_ack_i            (io_ack_i),
    .cart_ack_i          (cart_ack_i),
    .ppu_rdata_i         (ppu_rdata_i),
    .io_rdata_i          (io_rdata_i),
    .cart_rdata_i        (cart_rdata_i),
    .timeout_o           (timeout_o)
  );

  typedef struct {
    logic [15:0] addr;
    bit          wr;
    logic [7:0]  wdata;
    int          tgt;       // -1 = RAM
    int          lat;
    logic [7:0]  tdata;
    bit          noise_io;
    logic [7:0]  exp_rdata;
    int          exp_n;
    int          exp_req;
    bit          exp_to;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance to the next falling edge, observe outputs, update responders.
  task automatic step();
    @(negedge clock_i);
    garb = 8'($urandom);
    for (int t = 0; t < 3; t++) begin
      if (req_vec[t]) begin
        rcnt[t]++;
        req_cycles[t]++;
      end else begin
        rcnt[t] = 0;
      end
      ack_v[t] = noise[t] || (req_vec[t] && lat[t] != 0 && rcnt[t] == lat[t]);
    end
    if (timeout_o) timeout_pulses++;
  endtask

  task automatic wait_valid(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 100 && !ok) begin
      step();
      n++;
      if (cpu_data_valid_o) ok = 1'b1;
    end
  endtask

  task automatic do_access(input logic [15:0] a, input bit w, input logic [7:0] wd,
                           output logic [7:0] rd, output int n, output bit ok);
    for (int t = 0; t < 3; t++) req_cycles[t] = 0;
    timeout_pulses = 0;
    cpu_address = a;
    cpu_write   = w;
    cpu_wdata   = wd;
    cpu_valid   = 1'b1;
    wait_valid(n, ok);
    rd = cpu_rdata_o;
    if (a < 16'h2000 && w) begin
      ram_model[a & 16'h07FF] = wd;
      ram_valid[a & 16'h07FF] = 1'b1;
    end
  endtask

  task automatic release_bus();
    cpu_valid = 1'b0;
    step();
  endtask

  task automatic set_targets(input int tgt, input int l, input logic [7:0] d);
    for (int t = 0; t < 3; t++) begin
      lat[t]   = 0;
      noise[t] = 1'b0;
      tdata[t] = 8'h00;
    end
    if (tgt >= 0) begin
      lat[tgt]   = l;
      tdata[tgt] = d;
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         n;
    bit         ok;
    int         vcount;
    vec_t       v;

    reset_i     = 1'b0;
    cpu_address = '0;
    cpu_valid   = 1'b0;
    cpu_write   = 1'b0;
    cpu_wdata   = '0;
    ack_v       = '0;
    garb        = '0;
    set_targets(-1, 0, 8'h00);
    for (int t = 0; t < 3; t++) rcnt[t] = 0;
    for (int i = 0; i < 2048; i++) ram_valid[i] = 1'b0;

    // ---- Reset state ----
    #2 reset_i = 1'b1;
    repeat (2) @(negedge clock_i);
    check("reset valid", cpu_data_valid_o, 0);
    check("reset rdata", cpu_rdata_o, 8'h00);
    check("reset reqs", req_vec, 3'b000);
    check("reset ext_address", ext_address_o, 16'h0000);
    check("reset ext_write/wdata", {ext_write_o, ext_wdata_o}, 9'h000);
    check("reset timeout", timeout_o, 0);
    reset_i = 1'b0;

    // ---- Directed vector table ----
    //            addr    wr wdata tgt lat tdata noise exp_rd n   req to
    vecs.push_back('{16'hFFFC, 0, 8'h00,  2,  3, 8'h34, 0, 8'h34,  4,  3, 0});
    vecs.push_back('{16'hFFFD, 0, 8'h00,  2,  3, 8'h12, 0, 8'h12,  4,  3, 0});
    vecs.push_back('{16'h0005, 1, 8'hA5, -1,  0, 8'h00, 0, 8'hA5,  2,  0, 0});
    vecs.push_back('{16'h1805, 0, 8'h00, -1,  0, 8'h00, 0, 8'hA5,  2,  0, 0});
    vecs.push_back('{16'h3FFA, 0, 8'h00,  0,  1, 8'h80, 1, 8'h80,  2,  1, 0});
    vecs.push_back('{16'h0000, 1, 8'h5C, -1,  0, 8'h00, 0, 8'h5C,  2,  0, 0});
    vecs.push_back('{16'h0000, 0, 8'h00, -1,  0, 8'h00, 0, 8'h5C,  2,  0, 0});
    vecs.push_back('{16'h5000, 0, 8'h00,  2,  0, 8'h00, 0, 8'h5C, 65, 64, 1});
    vecs.push_back('{16'h8000, 0, 8'h00,  2, 64, 8'h99, 0, 8'h99, 65, 64, 0});
    vecs.push_back('{16'h4014, 1, 8'h3C,  1,  2, 8'hEE, 0, 8'h3C,  3,  2, 0});
    vecs.push_back('{16'h4020, 0, 8'h00,  2,  0, 8'h00, 0, 8'h3C, 65, 64, 1});
    vecs.push_back('{16'h401F, 0, 8'h00,  1,  1, 8'h41, 0, 8'h41,  2,  1, 0});
    vecs.push_back('{16'h07FF, 1, 8'h77, -1,  0, 8'h00, 0, 8'h77,  2,  0, 0});
    vecs.push_back('{16'h1FFF, 0, 8'h00, -1,  0, 8'h00, 0, 8'h77,  2,  0, 0});
    vecs.push_back('{16'h2000, 0, 8'h00,  0,  5, 8'hC3, 0, 8'hC3,  6,  5, 0});

    foreach (vecs[i]) begin
      v = vecs[i];
      set_targets(v.tgt, v.lat, v.tdata);
      if (v.noise_io) noise[1] = 1'b1;
      do_access(v.addr, v.wr, v.wdata, rd, n, ok);
      check($sformatf("v%0d completed", i), ok, 1);
      check($sformatf("v%0d rdata", i), rd, v.exp_rdata);
      check($sformatf("v%0d latency", i), n, v.exp_n);
      for (int t = 0; t < 3; t++)
        check($sformatf("v%0d req_cycles[%0d]", i, t), req_cycles[t], (t == v.tgt) ? v.exp_req : 0);
      check($sformatf("v%0d timeout pulses", i), timeout_pulses, v.exp_to);
      check($sformatf("v%0d ext_address", i), ext_address_o, v.addr);
      check($sformatf("v%0d ext_write", i), ext_write_o, v.wr);
      release_bus();
      check($sformatf("v%0d valid drops", i), cpu_data_valid_o, 0);
    end

    // ---- Held request is not re-issued; change leaves DONE with a bubble ----
    set_targets(0, 1, 8'h55);
    do_access(16'h2002, 0, 8'h00, rd, n, ok);
    check("hold completed", ok, 1);
    check("hold rdata", rd, 8'h55);
    repeat (5) step();
    check("hold valid stays", cpu_data_valid_o, 1);
    check("hold no reissue", req_cycles[0], 1);
    check("hold rdata stable", cpu_rdata_o, 8'h55);
    tdata[0]    = 8'h66;
    cpu_address = 16'h2003;
    step();
    check("change valid drops", cpu_data_valid_o, 0);
    check("change bubble no req", ppu_req_o, 0);
    step();
    check("change new req", ppu_req_o, 1);
    wait_valid(n, ok);
    check("change completed", ok, 1);
    check("change rdata", cpu_rdata_o, 8'h66);
    release_bus();

    // ---- Reset during EXT_WAIT ----
    set_targets(1, 0, 8'h00);
    cpu_address = 16'h4016;
    cpu_write   = 1'b0;
    cpu_valid   = 1'b1;
    repeat (3) step();
    check("midreset io_req before", io_req_o, 1);
    #2 reset_i = 1'b1;
    #1;
    check("midreset io_req async", io_req_o, 0);
    check("midreset valid async", cpu_data_valid_o, 0);
    check("midreset rdata", cpu_rdata_o, 8'h00);
    cpu_valid = 1'b0;
    @(negedge clock_i);
    reset_i  = 1'b0;
    noise[1] = 1'b1;
    vcount   = 0;
    repeat (4) begin
      step();
      if (cpu_data_valid_o) vcount++;
    end
    check("late ack no completion", vcount, 0);
    check("late ack no req", req_vec, 3'b000);
    noise[1] = 1'b0;
    step();

    // ---- Randomized traffic against the behavioural model ----
    ob = 8'h00;
    for (int r = 0; r < 150; r++) begin
      int          region;
      int          tgt;
      int          k;
      int          l;
      int          exp_n;
      bit          exp_to;
      logic [15:0] a;
      bit          w;
      logic [7:0]  wd;
      logic [7:0]  td;
      logic [7:0]  exp_rd;

      region = int'($urandom_range(0, 3));
      case (region)
        0:       a = 16'($urandom_range(16'h0000, 16'h1FFF));
        1:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
        2:       a = 16'($urandom_range(16'h4000, 16'h401F));
        default: a = 16'($urandom_range(16'h4020, 16'hFFFF));
      endcase
      w  = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      td = 8'($urandom);
      if (region == 0 && !w && !ram_valid[a & 16'h07FF]) w = 1'b1;
      k = int'($urandom_range(0, 9));
      l = (k == 0) ? 0 : (k == 1) ? 64 : int'($urandom_range(1, 6));
      if (w && l == 0) l = 3;
      tgt = region - 1;
      set_targets(tgt, l, td);
      for (int t = 0; t < 3; t++)
        if (t != tgt) noise[t] = 1'($urandom_range(0, 1));

      exp_to = 1'b0;
      if (region == 0) begin
        exp_n  = 2;
        exp_rd = w ? wd : ram_model[a & 16'h07FF];
      end else if (l != 0) begin
        exp_n  = l + 1;
        exp_rd = w ? wd : td;
      end else begin
        exp_n  = 65;
        exp_rd = ob;
        exp_to = 1'b1;
      end

      do_access(a, w, wd, rd, n, ok);
      check($sformatf("r%0d completed", r), ok, 1);
      check($sformatf("r%0d rdata a=%04h w=%0d", r, a, w), rd, exp_rd);
      check($sformatf("r%0d latency", r), n, exp_n);
      check($sformatf("r%0d timeout", r), timeout_pulses, exp_to);
      ob = exp_rd;
      if ($urandom_range(0, 3) == 0) begin
        repeat (3) step();
        check($sformatf("r%0d hold valid", r), cpu_data_valid_o, 1);
        check($sformatf("r%0d hold reqs", r),
              req_cycles[0] + req_cycles[1] + req_cycles[2],
              (region == 0) ? 0 : ((l == 0) ? 64 : l));
      end
      release_bus();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
